tt_um_pyamnihc_counter_checker: RTL
===================================

# tt_um_pyamnihc_counter_checker

Sequence checker that receives the 8-bit free-running count produced by the dummy counter tile and verifies it increments by one per qualified sample. It hunts for the sequence, locks after a run of consecutive matches, then counts mismatches and reports lock status and error count on the standard tile pins. It sits downstream of the counter tile and turns the counter's output into a self-checking loopback, either on silicon or in the cocotb bench.

## Interface
Parameters:
- `LOCK_COUNT`, default 4: consecutive matches required after the first sample before `locked` asserts. Legal range 1..15.
- `MISS_LIMIT`, default 2: consecutive mismatches while locked that drop the block back to HUNT. Legal range 1..15.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ena`  in  1  tile enable. While low, no state or counter changes; outputs hold.
- `ui_in`  in  8  observed counter value.
- `uio_in`  in  8  [0] `in_valid` sample qualifier; [1] `clr_err`; [2] `disp_sel` (0 = error count, 1 = last sample); [7:3] ignored.
- `uo_out`  out  8  `disp_sel`=0: `err_cnt`; `disp_sel`=1: last accepted sample.
- `uio_out`  out  8  [3] `locked`; [4] `mismatch` (1-cycle pulse); [5] `err_sat`; [6] `hunting`; [2:0] and [7] are 0.
- `uio_oe`  out  8  constant 8'hF8.

## Operation
- A sample is accepted on a rising edge with `ena`=1 and `in_valid`=1. `expected` is WIDTH-8 modulo arithmetic: 8'hFF is followed by 8'h00 as a legal match.
- States:
  - HUNT: the first accepted sample sets `expected`=sample+1, `match_cnt`=0, and moves to LOCKING.
  - LOCKING: on a match, `match_cnt`++ and `expected`++. When `match_cnt` reaches LOCK_COUNT, move to LOCKED. On a mismatch, resync `expected`=sample+1, clear `match_cnt`, and stay in LOCKING. No errors are counted in this state.
  - LOCKED: on a match, `expected`++ and `miss_cnt`=0. On a mismatch:
    - pulse `mismatch` for one cycle;
    - `err_cnt`++, saturating at 8'hFF, with `err_sat`=1 once it reaches 8'hFF;
    - `miss_cnt`++ and `expected`=sample+1;
    - if `miss_cnt` reaches MISS_LIMIT, go to HUNT with `match_cnt`=0 and `miss_cnt`=0.
- `clr_err`=1 (with `ena`=1) clears `err_cnt` and `err_sat`. Clearing has priority over a simultaneous increment: the result is 0. `clr_err` does not affect the FSM.
- `locked`=1 only in LOCKED. `hunting`=1 only in HUNT.
- Last-sample register loads on every accepted sample, in every state.
- `disp_sel` is a combinational mux select onto registered sources.
- `rst` mid-operation: on the next edge, return to HUNT and clear all registers, regardless of `ena`.

## Timing
- Reset values: state HUNT, `uo_out`=8'h00, `uio_out`=8'h40 (`hunting`=1), `uio_oe`=8'hF8, `err_cnt`=0, `expected`=0, `match_cnt`=0, `miss_cnt`=0.
- All status is registered. An accepted sample at edge N is reflected in `locked`, `mismatch`, `err_cnt`, `hunting` and the last-sample register immediately after edge N, with 1-cycle latency.
- `mismatch` is high for exactly one cycle per mismatching sample in LOCKED. It is low in every cycle with no accepted sample.
- Lock timing with continuous valid samples: `locked` rises after edge LOCK_COUNT+1 counted from the first sample.
- `in_valid` may be low for arbitrary gaps. `expected` holds across gaps, so gaps are not errors.
- A change on `disp_sel` is visible on `uo_out` in the same cycle, with no added register stage.

## Test plan
- Reset then continuous count: feed 8'h10, 8'h11, … with `in_valid`=1 every cycle. Required: `locked` rises after the 5th edge; `err_cnt`=0; `hunting` falls after the 1st edge.
- Wrap-around while locked: feed …8'hFE, 8'hFF, 8'h00, 8'h01. Required: no `mismatch`, `err_cnt`=0, `locked` stays 1.
- Single glitch while locked: feed 8'h20, 8'h21, 8'h55, 8'h56. Required:
  - one `mismatch` pulse after the 8'h55 edge;
  - `err_cnt`=1 and `locked` stays 1;
  - no further errors, because of the resync to 8'h56.
- Loss of lock: feed two consecutive non-sequential values while locked (8'h30, 8'h90, 8'h05). Required: `err_cnt`=2, then `hunting`=1 and `locked`=0; relock after 5 more sequential samples.
- Gaps and `ena`: insert `in_valid`=0 cycles and `ena`=0 cycles carrying garbage on `ui_in` inside a sequential stream. Required: no state change, no errors, last sample unchanged during the gaps.
- Saturation and clear: force 300 mismatches while locked with MISS_LIMIT=15, using alternating resync patterns. Required:
  - `err_cnt`=8'hFF and `err_sat`=1;
  - `clr_err` asserted in the same cycle as a mismatch gives `err_cnt`=0 and `err_sat`=0;
  - `disp_sel`=1 shows the last sample on `uo_out`.

Source files
------------

// File: rtl/tt_um_pyamnihc_counter_checker.sv
// Sequence checker for the dummy counter tile: hunts for an incrementing 8-bit
// count, locks after a run of matches, then counts and reports mismatches.
module tt_um_pyamnihc_counter_checker #(
    parameter int LOCK_COUNT = 4,
    parameter int MISS_LIMIT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [1:0] ST_HUNT    = 2'd0;
    localparam logic [1:0] ST_LOCKING = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    localparam logic [3:0] LOCK_TGT = 4'(LOCK_COUNT);
    localparam logic [3:0] MISS_TGT = 4'(MISS_LIMIT);

    // Modulo-256 successor of a sample; 8'hFF wraps to 8'h00.
    function automatic logic [7:0] inc8(input logic [7:0] value);
        return value + 8'd1;
    endfunction

    // Error counter increment that sticks at 8'hFF.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = 8'hFF;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

    logic       in_valid_s;
    logic       clr_err_s;
    logic       disp_sel_s;
    logic       accept_s;
    logic       hit_s;
    logic       err_inc_s;
    logic [3:0] match_inc_s;
    logic [3:0] miss_inc_s;

    logic [1:0] state_r, state_s;
    logic [7:0] expected_r, expected_s;
    logic [3:0] match_cnt_r, match_cnt_s;
    logic [3:0] miss_cnt_r, miss_cnt_s;
    logic [7:0] err_cnt_r, err_cnt_s;
    logic       err_sat_r, err_sat_s;
    logic       mismatch_r, mismatch_s;
    logic [7:0] last_r, last_s;
    logic       locked_r;
    logic       hunting_r;

    logic       unused_s;

    assign in_valid_s  = uio_in[0];
    assign clr_err_s   = uio_in[1];
    assign disp_sel_s  = uio_in[2];
    assign unused_s    = &{1'b0, uio_in[7:3]};

    assign accept_s    = ena & in_valid_s;
    assign hit_s       = (ui_in == expected_r);
    assign match_inc_s = match_cnt_r + 4'd1;
    assign miss_inc_s  = miss_cnt_r + 4'd1;

    // Next-state logic of the hunt / locking / locked sequence tracker.
    always_comb begin
        state_s     = state_r;
        expected_s  = expected_r;
        match_cnt_s = match_cnt_r;
        miss_cnt_s  = miss_cnt_r;
        mismatch_s  = 1'b0;
        err_inc_s   = 1'b0;
        if (accept_s) begin
            case (state_r)
                ST_HUNT: begin
                    expected_s  = inc8(ui_in);
                    match_cnt_s = 4'd0;
                    miss_cnt_s  = 4'd0;
                    state_s     = ST_LOCKING;
                end
                ST_LOCKING: begin
                    if (hit_s) begin
                        expected_s  = inc8(expected_r);
                        match_cnt_s = match_inc_s;
                        if (match_inc_s == LOCK_TGT) begin
                            state_s = ST_LOCKED;
                        end else begin
                            state_s = ST_LOCKING;
                        end
                    end else begin
                        // Resync silently: errors are only counted once locked.
                        expected_s  = inc8(ui_in);
                        match_cnt_s = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (hit_s) begin
                        expected_s = inc8(expected_r);
                        miss_cnt_s = 4'd0;
                    end else begin
                        mismatch_s = 1'b1;
                        err_inc_s  = 1'b1;
                        expected_s = inc8(ui_in);
                        if (miss_inc_s == MISS_TGT) begin
                            state_s     = ST_HUNT;
                            match_cnt_s = 4'd0;
                            miss_cnt_s  = 4'd0;
                        end else begin
                            miss_cnt_s = miss_inc_s;
                        end
                    end
                end
                default: begin
                    state_s     = ST_HUNT;
                    match_cnt_s = 4'd0;
                    miss_cnt_s  = 4'd0;
                end
            endcase
        end else begin
            mismatch_s = 1'b0;
        end
    end

    // Error counter and saturation flag; a clear wins over a same-cycle increment.
    always_comb begin
        err_cnt_s = err_cnt_r;
        err_sat_s = err_sat_r;
        if (ena && clr_err_s) begin
            err_cnt_s = 8'h00;
            err_sat_s = 1'b0;
        end else if (err_inc_s) begin
            err_cnt_s = sat_inc8(err_cnt_r);
            err_sat_s = (sat_inc8(err_cnt_r) == 8'hFF);
        end else begin
            err_cnt_s = err_cnt_r;
            err_sat_s = err_sat_r;
        end
    end

    // Last accepted sample, loaded in every state.
    always_comb begin
        last_s = last_r;
        if (accept_s) begin
            last_s = ui_in;
        end else begin
            last_s = last_r;
        end
    end

    // State and status registers; reset overrides the tile enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_HUNT;
            expected_r  <= 8'h00;
            match_cnt_r <= 4'd0;
            miss_cnt_r  <= 4'd0;
            err_cnt_r   <= 8'h00;
            err_sat_r   <= 1'b0;
            mismatch_r  <= 1'b0;
            last_r      <= 8'h00;
            locked_r    <= 1'b0;
            hunting_r   <= 1'b1;
        end else begin
            state_r     <= state_s;
            expected_r  <= expected_s;
            match_cnt_r <= match_cnt_s;
            miss_cnt_r  <= miss_cnt_s;
            err_cnt_r   <= err_cnt_s;
            err_sat_r   <= err_sat_s;
            mismatch_r  <= mismatch_s;
            last_r      <= last_s;
            locked_r    <= (state_s == ST_LOCKED);
            hunting_r   <= (state_s == ST_HUNT);
        end
    end

    // The display select only steers between already-registered values.
    assign uo_out  = disp_sel_s ? last_r : err_cnt_r;
    assign uio_out = {1'b0, hunting_r, err_sat_r, mismatch_r, locked_r, 3'b000};
    assign uio_oe  = 8'hF8;

endmodule
